time_syn_ctrl: RTL
==================

TIME_SYN_CTRL -- requirements
Module: time_syn_ctrl

Interface
REQ-001 Parameter P_TICK_NS, default 64'd8: local-time increment per clock, in ns.
REQ-002 Parameter P_TIMEOUT, default 16'd1000: clock cycles allowed for a return frame before the exchange is aborted.
REQ-003 i_clk  in  1  clock.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_syn_start  in  1  one-cycle pulse; starts a two-way sync exchange.
REQ-006 i_recv_time_stamp  in  64  peer request timestamp; qualified by i_recv_ts_valid.
REQ-007 i_recv_ts_valid  in  1  one-cycle pulse; peer request received.
REQ-008 i_recv_std_time  in  64  standard time; qualified by i_recv_std_valid.
REQ-009 i_recv_std_valid  in  1  one-cycle pulse; standard-time frame received.
REQ-010 i_recv_return_ts  in  64  peer receive time of our request (T2); qualified by i_recv_return_valid.
REQ-011 i_recv_return_valid  in  1  one-cycle pulse; return frame received.
REQ-012 o_local_time  out  64  free-running local time, ns.
REQ-013 o_send_req  out  1  one-cycle pulse; transmit a sync request.
REQ-014 o_send_ts  out  64  T1 carried by the request; valid with o_send_req and held until the next request.
REQ-015 o_return_req  out  1  one-cycle pulse; transmit a return frame.
REQ-016 o_return_ts  out  64  local receive time of the peer request; held until the next return.
REQ-017 o_link_delay  out  64  last computed one-way delay, ns.
REQ-018 o_syn_done  out  1  one-cycle pulse; local time corrected.
REQ-019 o_syn_fail  out  1  one-cycle pulse; exchange aborted.
REQ-020 o_busy  out  1  high in every FSM state except IDLE.

Function
REQ-021 o_local_time shall increase by P_TICK_NS every cycle, with modulo 2^64 wrap, unless it is loaded.
REQ-022 Local-time load priority per cycle, highest first:
- std load: o_local_time <= i_recv_std_time + P_TICK_NS.
- ADJUST load.
- increment.
REQ-023 The FSM shall use the states IDLE, SEND, WAIT_RET, CALC and ADJUST, registered, one state per cycle except WAIT_RET.
REQ-024 IDLE: i_syn_start without i_recv_std_valid in the same cycle -> SEND; i_syn_start in any other state is ignored.
REQ-025 SEND: capture T1 = o_local_time; assert o_send_req and o_send_ts = T1 on the next cycle; clear the timeout counter; -> WAIT_RET.
REQ-026 WAIT_RET: i_recv_return_valid -> capture T2 = i_recv_return_ts and T4 = o_local_time in that same cycle; -> CALC.
REQ-027 WAIT_RET: the 16-bit timeout counter increments each cycle; on reaching P_TIMEOUT, pulse o_syn_fail and go to IDLE.
REQ-028 CALC: o_link_delay <= (T4 - T1) >> 1, unsigned; if T4 < T1 (wrap or corrupt frame), o_link_delay <= 0; -> ADJUST.
REQ-029 ADJUST: o_local_time <= T2 + o_link_delay + P_TICK_NS; o_syn_done pulses on the following cycle; -> IDLE.
REQ-030 Latency: o_syn_done rises 3 cycles after the cycle in which i_recv_return_valid is sampled.
REQ-031 i_recv_std_valid while not in IDLE:
- load local time per REQ-022;
- abort to IDLE and pulse o_syn_fail next cycle;
- do not update o_link_delay (if in CALC) and do not pulse o_syn_done.
REQ-032 i_recv_return_valid outside WAIT_RET shall be ignored.
REQ-033 Responder path, independent of the FSM: on i_recv_ts_valid, o_return_ts <= o_local_time of that cycle, and o_return_req pulses on the next cycle.
REQ-034 Back-to-back i_recv_ts_valid pulses shall each produce one o_return_req pulse.
REQ-035 o_syn_done and o_syn_fail shall never be high in the same cycle.
REQ-036 All arithmetic shall be 64-bit unsigned modulo 2^64.

Reset
REQ-037 While i_rst is high: FSM = IDLE; o_local_time, o_send_ts, o_return_ts, o_link_delay, T1, T2, T4 and the timeout counter = 0; all pulse outputs and o_busy = 0.
REQ-038 Deassertion of i_rst mid-exchange shall leave the block in IDLE with no o_syn_done or o_syn_fail pulse.
REQ-039 After reset release, o_local_time shall increment from 0 on the first clock edge.

Verification
REQ-040 Nominal exchange: i_syn_start at local time 800 -> o_send_ts = 800; return with T2 = 10000 while local time = 1200 -> o_link_delay = 200, local time set to 10208, o_syn_done pulses once.
REQ-041 Timeout: i_syn_start with no return for 1000 cycles -> o_syn_fail pulses once, o_busy falls, o_link_delay unchanged.
REQ-042 Std load: i_recv_std_valid with value 5000 while in WAIT_RET -> next o_local_time = 5008, o_syn_fail pulses, FSM in IDLE.
REQ-043 Simultaneous i_syn_start and i_recv_std_valid in IDLE -> std load only, o_send_req stays 0.
REQ-044 Responder: i_recv_ts_valid at local time 4096 -> next cycle o_return_req = 1, o_return_ts = 4096; two consecutive pulses -> two returns.
REQ-045 Wrap: T1 = 2^64-16, T4 = 16 -> o_link_delay = 0.

Source files
------------

// File: rtl/time_syn_ctrl.sv
// Two-way time synchronisation controller: free-running local clock, request/return
// exchange with the peer, one-way link-delay estimate and local-time correction.
module time_syn_ctrl #(
   parameter logic [63:0] P_TICK_NS = 64'd8,
   parameter logic [15:0] P_TIMEOUT = 16'd1000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_syn_start,
   input  logic [63:0] i_recv_time_stamp,
   input  logic        i_recv_ts_valid,
   input  logic [63:0] i_recv_std_time,
   input  logic        i_recv_std_valid,
   input  logic [63:0] i_recv_return_ts,
   input  logic        i_recv_return_valid,
   output logic [63:0] o_local_time,
   output logic        o_send_req,
   output logic [63:0] o_send_ts,
   output logic        o_return_req,
   output logic [63:0] o_return_ts,
   output logic [63:0] o_link_delay,
   output logic        o_syn_done,
   output logic        o_syn_fail,
   output logic        o_busy,
   output logic [2:0]  o_state_dbg
);

   // Handshakes: every *_valid input and *_req/_done/_fail output is a one-cycle
   // strobe with no back-pressure; a strobe is consumed in the cycle it is sampled.

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SEND     = 3'd1,
      S_WAIT_RET = 3'd2,
      S_CALC     = 3'd3,
      S_ADJUST   = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] local_time_q, local_time_d;
   logic [63:0] t1_q, t1_d;
   logic [63:0] t2_q, t2_d;
   logic [63:0] t4_q, t4_d;
   logic [15:0] cnt_q, cnt_d;
   logic [63:0] link_delay_q, link_delay_d;
   logic [63:0] send_ts_q, send_ts_d;
   logic [63:0] return_ts_q, return_ts_d;
   logic        send_req_q, send_req_d;
   logic        return_req_q, return_req_d;
   logic        syn_done_q, syn_done_d;
   logic        syn_fail_q, syn_fail_d;

   logic [15:0] cnt_inc;
   logic [63:0] rtt;
   logic [63:0] delay_calc;

   // The reply carries our own receive time, so the peer's timestamp is not needed.
   logic unused_rx_ts;
   assign unused_rx_ts = ^i_recv_time_stamp;

   assign cnt_inc    = cnt_q + 16'd1;
   assign rtt        = t4_q - t1_q;
   assign delay_calc = (t4_q < t1_q) ? 64'd0 : {1'b0, rtt[63:1]};

   always_comb begin
      state_d      = state_q;
      local_time_d = local_time_q + P_TICK_NS;
      t1_d         = t1_q;
      t2_d         = t2_q;
      t4_d         = t4_q;
      cnt_d        = cnt_q;
      link_delay_d = link_delay_q;
      send_ts_d    = send_ts_q;
      send_req_d   = 1'b0;
      syn_done_d   = 1'b0;
      syn_fail_d   = 1'b0;
      return_req_d = i_recv_ts_valid;
      return_ts_d  = i_recv_ts_valid ? local_time_q : return_ts_q;

      if (i_recv_std_valid) begin
         // Standard time overrides everything and kills any exchange in flight.
         local_time_d = i_recv_std_time + P_TICK_NS;
         syn_fail_d   = (state_q != S_IDLE);
         state_d      = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_syn_start) state_d = S_SEND;
            end
            S_SEND: begin
               t1_d       = local_time_q;
               send_ts_d  = local_time_q;
               send_req_d = 1'b1;
               cnt_d      = 16'd0;
               state_d    = S_WAIT_RET;
            end
            S_WAIT_RET: begin
               if (i_recv_return_valid) begin
                  t2_d    = i_recv_return_ts;
                  t4_d    = local_time_q;
                  state_d = S_CALC;
               end else begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == P_TIMEOUT) begin
                     syn_fail_d = 1'b1;
                     state_d    = S_IDLE;
                  end
               end
            end
            S_CALC: begin
               link_delay_d = delay_calc;
               state_d      = S_ADJUST;
            end
            S_ADJUST: begin
               local_time_d = t2_q + link_delay_q + P_TICK_NS;
               syn_done_d   = 1'b1;
               state_d      = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= S_IDLE;
         local_time_q <= 64'd0;
         t1_q         <= 64'd0;
         t2_q         <= 64'd0;
         t4_q         <= 64'd0;
         cnt_q        <= 16'd0;
         link_delay_q <= 64'd0;
         send_ts_q    <= 64'd0;
         return_ts_q  <= 64'd0;
         send_req_q   <= 1'b0;
         return_req_q <= 1'b0;
         syn_done_q   <= 1'b0;
         syn_fail_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         local_time_q <= local_time_d;
         t1_q         <= t1_d;
         t2_q         <= t2_d;
         t4_q         <= t4_d;
         cnt_q        <= cnt_d;
         link_delay_q <= link_delay_d;
         send_ts_q    <= send_ts_d;
         return_ts_q  <= return_ts_d;
         send_req_q   <= send_req_d;
         return_req_q <= return_req_d;
         syn_done_q   <= syn_done_d;
         syn_fail_q   <= syn_fail_d;
      end
   end

   assign o_local_time = local_time_q;
   assign o_send_req   = send_req_q;
   assign o_send_ts    = send_ts_q;
   assign o_return_req = return_req_q;
   assign o_return_ts  = return_ts_q;
   assign o_link_delay = link_delay_q;
   assign o_syn_done   = syn_done_q;
   assign o_syn_fail   = syn_fail_q;
   assign o_busy       = (state_q != S_IDLE);
   assign o_state_dbg  = state_q;

endmodule
